sram_sync_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port synchronous SRAM (1-cycle read latency, per-byte write enable) between a high-priority data port (P0) and a low-priority fetch port (P1). Grants combinationally, drives the SRAM directly, and routes the registered response back to the granting port. Fixed priority to P0, with a starvation counter that forces a P1 grant after a bounded number of consecutive losses.

---
 rtl/sram_sync_arbiter_pkg.sv | 13 +
 rtl/sram_sync_arbiter_if.sv | 51 +++++
 rtl/sram_sync_arbiter.sv | 86 ++++++++
 tb/tb_sram_sync_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_sync_arbiter_pkg.sv
// Shared types for the SRAM arbiter: response port index and counter sizing helper.
package sram_sync_arbiter_pkg;

  typedef enum logic {
    PORT_D = 1'b0,
    PORT_I = 1'b1
  } port_e;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sram_sync_arbiter_if.sv
// Bundle of both requester ports plus the SRAM bus seen by the arbiter.
interface sram_sync_arbiter_if #(
  parameter int W_ADDR = 11,
  parameter int W_DATA = 32
);
  localparam int W_STRB = W_DATA / 8;

  logic              p0_req;
  logic              p0_gnt;
  logic              p0_write;
  logic [W_ADDR-1:0] p0_addr;
  logic [W_STRB-1:0] p0_wstrb;
  logic [W_DATA-1:0] p0_wdata;
  logic              p0_rsp;
  logic [W_DATA-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_gnt;
  logic              p1_write;
  logic [W_ADDR-1:0] p1_addr;
  logic [W_STRB-1:0] p1_wstrb;
  logic [W_DATA-1:0] p1_wdata;
  logic              p1_rsp;
  logic [W_DATA-1:0] p1_rdata;

  logic [W_ADDR-1:0] sram_addr;
  logic              sram_ren;
  logic [W_STRB-1:0] sram_wen;
  logic [W_DATA-1:0] sram_wdata;
  logic [W_DATA-1:0] sram_rdata;

  // master = requesters plus the SRAM macro; slave = the arbiter itself
  modport master (
    output p0_req, p0_write, p0_addr, p0_wstrb, p0_wdata,
    output p1_req, p1_write, p1_addr, p1_wstrb, p1_wdata,
    output sram_rdata,
    input  p0_gnt, p0_rsp, p0_rdata,
    input  p1_gnt, p1_rsp, p1_rdata,
    input  sram_addr, sram_ren, sram_wen, sram_wdata
  );

  modport slave (
    input  p0_req, p0_write, p0_addr, p0_wstrb, p0_wdata,
    input  p1_req, p1_write, p1_addr, p1_wstrb, p1_wdata,
    input  sram_rdata,
    output p0_gnt, p0_rsp, p0_rdata,
    output p1_gnt, p1_rsp, p1_rdata,
    output sram_addr, sram_ren, sram_wen, sram_wdata
  );

endinterface

// File: rtl/sram_sync_arbiter.sv
// Fixed-priority arbiter sharing one synchronous SRAM between a data port (P0)
// and a fetch port (P1), with a starvation counter that forces a P1 grant.
module sram_sync_arbiter
  import sram_sync_arbiter_pkg::*;
#(
  parameter int W_ADDR     = 11,
  parameter int W_DATA     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_sync_arbiter_if.slave bus
);

  localparam int W_STRB = W_DATA / 8;
  localparam int CNT_W  = cnt_width(STARVE_MAX);

  logic [CNT_W-1:0]  starve_cnt;
  logic              force1;
  logic              grant0;
  logic              grant1;
  logic              rsp_valid;
  port_e             rsp_idx;

  logic              win_write;
  logic [W_ADDR-1:0] win_addr;
  logic [W_STRB-1:0] win_strb;
  logic [W_DATA-1:0] win_wdata;

  always_comb begin
    force1 = (starve_cnt == CNT_W'(STARVE_MAX));
    grant1 = bus.p1_req && (force1 || !bus.p0_req);
    grant0 = bus.p0_req && !grant1;
  end

  assign bus.p0_gnt = grant0;
  assign bus.p1_gnt = grant1;

  // Idle cycles present P0's payload; ren/wen are both held low then.
  always_comb begin
    win_write = bus.p0_write;
    win_addr  = bus.p0_addr;
    win_strb  = bus.p0_wstrb;
    win_wdata = bus.p0_wdata;
    if (grant1) begin
      win_write = bus.p1_write;
      win_addr  = bus.p1_addr;
      win_strb  = bus.p1_wstrb;
      win_wdata = bus.p1_wdata;
    end
  end

  always_comb begin
    bus.sram_addr  = win_addr;
    bus.sram_wdata = win_wdata;
    bus.sram_ren   = (grant0 || grant1) && !win_write;
    bus.sram_wen   = (grant0 || grant1) && win_write ? win_strb : '0;
  end

  // P1 only loses to a P0 grant, so any P1 request not granted counts as a loss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.p1_req || grant1) begin
      starve_cnt <= '0;
    end else if (!force1) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_idx   <= PORT_D;
    end else begin
      rsp_valid <= grant0 || grant1;
      rsp_idx   <= grant1 ? PORT_I : PORT_D;
    end
  end

  assign bus.p0_rsp   = rsp_valid && (rsp_idx == PORT_D);
  assign bus.p1_rsp   = rsp_valid && (rsp_idx == PORT_I);
  assign bus.p0_rdata = bus.sram_rdata;
  assign bus.p1_rdata = bus.sram_rdata;

endmodule

// File: tb/tb_sram_sync_arbiter.sv
// Scoreboard bench for sram_sync_arbiter: directed scenarios plus random traffic
// checked against a word-array memory model and a loss-count grant rule.
module tb_sram_sync_arbiter;

  localparam int W_ADDR     = 11;
  localparam int W_DATA     = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << W_ADDR;

  typedef struct packed {
    logic        v;
    logic        write;
    logic [10:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        port;
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  sram_sync_arbiter_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

  sram_sync_arbiter #(
    .W_ADDR    (W_ADDR),
    .W_DATA    (W_DATA),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle read latency, per-byte write enables.
  logic [31:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.sram_ren) bus.sram_rdata <= sram_mem[bus.sram_addr];
    for (int b = 0; b < 4; b++)
      if (bus.sram_wen[b]) sram_mem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
  end

  logic [31:0] ref_mem [DEPTH];
  int          ref_losses = 0;
  exp_t        exp_q [$];
  logic        last_eg0, last_eg1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic req_t rd(input logic [10:0] a);
    req_t r = '0;
    r.v = 1'b1; r.addr = a;
    return r;
  endfunction

  function automatic req_t wr(input logic [10:0] a, input logic [3:0] s, input logic [31:0] d);
    req_t r = '0;
    r.v = 1'b1; r.write = 1'b1; r.addr = a; r.strb = s; r.wdata = d;
    return r;
  endfunction

  // One clock cycle: drive at negedge, check grants, then advance the reference model.
  task automatic applyStimulus(input req_t r0, input req_t r1, input logic rst_val,
                               output logic g0, output logic g1);
    logic eg0, eg1;
    req_t w;
    exp_t e;
    @(negedge clk);
    rst_n        = rst_val;
    bus.p0_req   = r0.v;  bus.p0_write = r0.write; bus.p0_addr = r0.addr;
    bus.p0_wstrb = r0.strb; bus.p0_wdata = r0.wdata;
    bus.p1_req   = r1.v;  bus.p1_write = r1.write; bus.p1_addr = r1.addr;
    bus.p1_wstrb = r1.strb; bus.p1_wdata = r1.wdata;
    #1;
    eg1 = r1.v && (ref_losses >= STARVE_MAX || !r0.v);
    eg0 = r0.v && !eg1;
    checkOutput("p0_gnt", {31'b0, bus.p0_gnt}, {31'b0, eg0});
    checkOutput("p1_gnt", {31'b0, bus.p1_gnt}, {31'b0, eg1});
    g0 = bus.p0_gnt;
    g1 = bus.p1_gnt;
    last_eg0 = eg0;
    last_eg1 = eg1;
    if (eg0 || eg1) begin
      w = eg1 ? r1 : r0;
      e.port    = eg1;
      e.is_read = !w.write;
      e.data    = ref_mem[w.addr];
      if (w.write)
        for (int b = 0; b < 4; b++)
          if (w.strb[b]) ref_mem[w.addr][b*8 +: 8] = w.wdata[b*8 +: 8];
      if (rst_val) exp_q.push_back(e);
    end
    if (!rst_val || !r1.v || eg1) ref_losses = 0;
    else if (ref_losses < STARVE_MAX) ref_losses++;
  endtask

  // Monitor: every cycle, the head of the queue (if any) must be the response now showing.
  always @(posedge clk) begin
    exp_t e;
    logic have;
    #1;
    have = exp_q.size() > 0;
    e = '0;
    if (have) e = exp_q.pop_front();
    checkOutput("p0_rsp", {31'b0, bus.p0_rsp}, {31'b0, have && !e.port});
    checkOutput("p1_rsp", {31'b0, bus.p1_rsp}, {31'b0, have && e.port});
    if (have && e.is_read) begin
      if (e.port) checkOutput("p1_rdata", bus.p1_rdata, e.data);
      else        checkOutput("p0_rdata", bus.p0_rdata, e.data);
    end
  end

  initial begin
    req_t idle, pend0, pend1;
    logic g0, g1;
    idle = '0;

    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = 32'h5000_0000 ^ (i * 32'h0001_0203);
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[11'h010] = 32'hDEADBEEF; ref_mem[11'h010] = 32'hDEADBEEF;
    sram_mem[11'h020] = 32'hAAAAAAAA; ref_mem[11'h020] = 32'hAAAAAAAA;

    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    bus.p0_write = 1'b0; bus.p1_write = 1'b0;
    bus.p0_addr = '0; bus.p1_addr = '0;
    bus.p0_wstrb = '0; bus.p1_wstrb = '0;
    bus.p0_wdata = '0; bus.p1_wdata = '0;

    repeat (2) applyStimulus(idle, idle, 1'b0, g0, g1);
    applyStimulus(idle, idle, 1'b1, g0, g1);

    // single P0 read of preloaded word
    applyStimulus(rd(11'h010), idle, 1'b1, g0, g1);
    applyStimulus(idle, idle, 1'b1, g0, g1);

    // P1 partial write then read back
    applyStimulus(idle, wr(11'h020, 4'b0011, 32'h12345678), 1'b1, g0, g1);
    applyStimulus(idle, rd(11'h020), 1'b1, g0, g1);
    applyStimulus(idle, idle, 1'b1, g0, g1);
    checkOutput("merged_word", ref_mem[11'h020], 32'hAAAA5678);

    // both requesting continuously: P0 x4 then P1, repeating
    for (int i = 0; i < 10; i++) begin
      applyStimulus(rd(11'(i)), rd(11'(100 + i)), 1'b1, g0, g1);
      checkOutput("starve_pattern", {31'b0, g1}, {31'b0, (i % 5) == 4});
    end
    applyStimulus(idle, idle, 1'b1, g0, g1);

    // P1 drops its request after 3 losses; the count restarts
    for (int i = 0; i < 9; i++) begin
      applyStimulus(rd(11'(200 + i)), (i == 3) ? idle : rd(11'h300), 1'b1, g0, g1);
      checkOutput("drop_pattern", {31'b0, g1}, {31'b0, i == 8});
    end
    applyStimulus(idle, idle, 1'b1, g0, g1);

    // write then immediate read from the other port; zero-strobe write is a no-op
    applyStimulus(wr(11'h030, 4'hF, 32'hCAFEF00D), idle, 1'b1, g0, g1);
    applyStimulus(idle, rd(11'h030), 1'b1, g0, g1);
    applyStimulus(wr(11'h030, 4'h0, 32'h0BADF00D), idle, 1'b1, g0, g1);
    applyStimulus(rd(11'h030), idle, 1'b1, g0, g1);
    applyStimulus(idle, idle, 1'b1, g0, g1);
    checkOutput("zero_strobe_word", ref_mem[11'h030], 32'hCAFEF00D);

    // reset lands on a granted read with the counter part-way up
    applyStimulus(rd(11'h040), rd(11'h041), 1'b1, g0, g1);
    applyStimulus(rd(11'h042), rd(11'h041), 1'b1, g0, g1);
    applyStimulus(rd(11'h010), rd(11'h041), 1'b0, g0, g1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(rd(11'(i)), rd(11'h041), 1'b1, g0, g1);
      checkOutput("post_reset_pattern", {31'b0, g1}, {31'b0, i == 4});
    end
    applyStimulus(rd(11'h010), idle, 1'b1, g0, g1);
    applyStimulus(idle, idle, 1'b1, g0, g1);

    // random traffic; requests hold their payload until granted
    pend0 = '0;
    pend1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0.v && $urandom_range(0, 9) < 6)
        pend0 = $urandom_range(0, 1) ? wr(11'($urandom_range(0, 15)), 4'($urandom), $urandom)
                                      : rd(11'($urandom_range(0, 15)));
      if (!pend1.v && $urandom_range(0, 9) < 7)
        pend1 = $urandom_range(0, 3) == 0 ? wr(11'($urandom_range(0, 15)), 4'($urandom), $urandom)
                                          : rd(11'($urandom_range(0, 15)));
      applyStimulus(pend0, pend1, 1'b1, g0, g1);
      if (last_eg0) pend0 = '0;
      if (last_eg1) pend1 = '0;
    end

    repeat (3) applyStimulus(idle, idle, 1'b1, g0, g1);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
